// File: rtl/icache_pkg.sv
// Shared instruction-cache definitions: geometry, controller state encoding and
// address field helpers used by the miss controller, tag array and data array.
package icache_pkg;

    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int INDEX_W  = 6;
    localparam int OFFSET_W = 4;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORDS    = 4;
    localparam int WORD_W   = $clog2(WORDS);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LOOKUP   = 2'd1,
        ST_MISS_REQ = 2'd2,
        ST_REFILL   = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [WORD_W-1:0] addr_word(input logic [ADDR_W-1:0] a);
        return a[2 +: WORD_W];
    endfunction

    function automatic logic [ADDR_W-1:0] addr_line_base(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_miss_controller.sv
// Direct-mapped icache control: lookup, hit return, line refill from a 4-beat
// memory burst, and deferred fence.i flush sequencing onto the tag array.
module icache_miss_controller
    import icache_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_req_valid,
    input  logic [ADDR_W-1:0]   cpu_req_addr,
    output logic                cpu_req_ready,
    output logic                cpu_resp_valid,
    output logic [DATA_W-1:0]   cpu_resp_data,
    input  logic                flush_req,
    output logic [INDEX_W-1:0]  tag_lookup_index,
    output logic [TAG_W-1:0]    tag_lookup_tag,
    input  logic                tag_hit,
    output logic                tag_update_valid,
    output logic [INDEX_W-1:0]  tag_update_index,
    output logic [TAG_W-1:0]    tag_update_tag,
    output logic                tag_flush_all,
    output logic [INDEX_W-1:0]  data_rd_index,
    output logic [WORD_W-1:0]   data_rd_word,
    input  logic [DATA_W-1:0]   data_rd_data,
    output logic                data_wr_en,
    output logic [INDEX_W-1:0]  data_wr_index,
    output logic [WORD_W-1:0]   data_wr_word,
    output logic [DATA_W-1:0]   data_wr_data,
    output logic                mem_req_valid,
    output logic [ADDR_W-1:0]   mem_req_addr,
    input  logic                mem_req_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    state_t              state_q;
    state_t              state_d;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [WORD_W-1:0]   beat_q;
    logic                flush_pend_q;

    logic                flush_now;
    logic                accept;
    logic                beat_vld;
    logic                last_beat;
    logic                lookup_hit;

    // A flush, new or deferred, always takes the IDLE cycle ahead of a fetch.
    assign flush_now  = (state_q == ST_IDLE) && (flush_req || flush_pend_q);
    assign accept     = (state_q == ST_IDLE) && !flush_now && cpu_req_valid;
    assign lookup_hit = (state_q == ST_LOOKUP) && tag_hit;
    assign beat_vld   = (state_q == ST_REFILL) && mem_rvalid;
    assign last_beat  = beat_vld && (beat_q == WORD_W'(WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept)        state_d = ST_LOOKUP;
            ST_LOOKUP:   state_d = tag_hit ? ST_IDLE : ST_MISS_REQ;
            ST_MISS_REQ: if (mem_req_ready) state_d = ST_REFILL;
            ST_REFILL:   if (last_beat)     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cpu_req_ready    = (state_q == ST_IDLE) && !flush_req && !flush_pend_q;
        tag_flush_all    = flush_now;
        tag_lookup_index = addr_index(req_addr_q);
        tag_lookup_tag   = addr_tag(req_addr_q);
        data_rd_index    = addr_index(req_addr_q);
        data_rd_word     = addr_word(req_addr_q);
        // The tag is only validated once the whole line is in the data array.
        tag_update_valid = last_beat;
        tag_update_index = addr_index(req_addr_q);
        tag_update_tag   = addr_tag(req_addr_q);
        data_wr_en       = beat_vld;
        data_wr_index    = addr_index(req_addr_q);
        data_wr_word     = beat_q;
        data_wr_data     = mem_rdata;
        mem_req_valid    = (state_q == ST_MISS_REQ);
        mem_req_addr     = (state_q == ST_MISS_REQ) ? addr_line_base(req_addr_q) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr_q     <= '0;
            beat_q         <= '0;
            flush_pend_q   <= 1'b0;
            cpu_resp_valid <= 1'b0;
            cpu_resp_data  <= '0;
        end else begin
            if (accept) begin
                req_addr_q <= cpu_req_addr;
            end
            if ((state_q == ST_MISS_REQ) && mem_req_ready) begin
                beat_q <= '0;
            end else if (beat_vld) begin
                beat_q <= beat_q + 1'b1;
            end
            if (state_q == ST_IDLE) begin
                flush_pend_q <= 1'b0;
            end else if (flush_req) begin
                flush_pend_q <= 1'b1;
            end
            if (lookup_hit) begin
                cpu_resp_data <= data_rd_data;
            end else if (beat_vld && (beat_q == addr_word(req_addr_q))) begin
                cpu_resp_data <= mem_rdata;
            end
            cpu_resp_valid <= lookup_hit || last_beat;
        end
    end

endmodule
